cell_result_collector: RTL and testbench
========================================

// Module: cell_result_collector
// PURPOSE
//  Downstream of the MemoryCell array. Snapshots the per-cell response vectors (bool/result/context)
//  one cycle after a broadcast command and scans them serially. Returns the lowest-handle asserting
//  cell with its value and context to the host sequencer via valid/ready.
//  Serves lookUpScan (1), encode (2), markAvailableCell (5) and enrank (6).
// PARAMETERS
//  NUM_CELLS  8  cells in the array; cell i has handle i; 1..255
//  DATA_W     8  width of each cell result/context field
//  IDX_W      8  handle/index width; 2^IDX_W >= NUM_CELLS
// PORTS
//  clk            in   1                  clock, rising edge
//  reset          in   1                  synchronous, active-low
//  in_valid       in   1                  cell vectors below hold a completed command response
//  in_ready       out  1                  collector can accept a snapshot
//  cell_bool      in   NUM_CELLS          bit i = new_bool of cell i
//  cell_result    in   NUM_CELLS*DATA_W   [i*DATA_W +: DATA_W] = new_result_value of cell i
//  cell_context   in   NUM_CELLS*DATA_W   [i*DATA_W +: DATA_W] = new_context of cell i
//  out_valid      out  1                  scan result available
//  out_ready      in   1                  host consumes result
//  out_hit        out  1                  at least one cell asserted bool
//  out_handle     out  IDX_W              handle of lowest asserting cell; 0 if no hit
//  out_value      out  DATA_W             result value of that cell; 0 if no hit
//  out_context    out  DATA_W             context of that cell; 0 if no hit
//  out_hit_count  out  IDX_W+1            number of asserting cells; 0 when HIT_COUNT_EN is undefined
// BEHAVIOUR
//  - Reset: sampled on posedge clk while reset==0.
//    - State IDLE; in_ready=1; out_valid=0; all out_* =0; scan index=0; snapshot registers=0.
//  - FSM IDLE -> SCAN -> DONE -> IDLE.
//    - IDLE: in_ready=1. On an edge with in_valid=1:
//      - copy cell_bool/result/context into the snapshot;
//      - clear hit, handle, value, context and count; idx=0; go to SCAN.
//    - SCAN: in_ready=0. Each edge examines snapshot cell idx:
//      - if bool[idx]=1 and no hit is held yet: set hit=1, handle=idx, and latch that cell's value and context;
//      - idx increments; after the edge that examines idx=NUM_CELLS-1, go to DONE.
//    - DONE: out_valid=1; outputs stay stable. On an edge with out_ready=1, go to IDLE and drop out_valid.
//  - Latency:
//    - out_valid rises exactly NUM_CELLS edges after the accepting edge.
//    - Scan is always full length; there is no early exit.
//    - Minimum accept-to-accept spacing is NUM_CELLS+2 edges, when out_ready is held high.
//  - Input vectors are ignored outside IDLE. Changing cell vectors during SCAN must not affect the result.
//  - Priority: the lowest index wins. Later hits never overwrite the held value or context.
//  - No hit: out_hit=0, out_handle=0, out_value=0, out_context=0.
//  - out_handle is idx zero-extended to IDX_W. The count saturates at 2^(IDX_W+1)-1; this is unreachable for legal NUM_CELLS.
//  - Reset while in SCAN or DONE: return to IDLE immediately; the pending result is discarded and out_valid=0 on the next cycle.
//  - out_valid=1 with out_ready=0: hold every output unchanged indefinitely. in_ready stays 0.
// CONFIGURATION
//  HIT_COUNT_EN defined:
//   - the count register increments on every asserting cell examined during SCAN;
//   - out_hit_count is valid together with out_valid. Host uses it to detect duplicate matches on lookUpScan.
//  HIT_COUNT_EN undefined:
//   - the count logic is removed and out_hit_count is tied to 0;
//   - all other behaviour and latency are identical.
// TESTING (NUM_CELLS=8, DATA_W=8)
//  1. Reset, then in_valid with bool=8'b0010_0100, result[2]=0x11, ctx[2]=0x03, result[5]=0x22, out_ready=1
//     -> out_valid exactly 8 edges after accept; hit=1, handle=2, value=0x11, context=0x03, count=2 (EN) / 0 (no EN).
//  2. bool=8'h00 -> out_valid after 8 edges; hit=0, handle=0, value=0, context=0, count=0.
//  3. bool=8'h80, result[7]=0xAB; out_ready=0 for 5 cycles, then 1
//     -> outputs stay handle=7, value=0xAB throughout; in_ready=0 until the edge after the transfer.
//  4. Accept bool=8'h01, then during SCAN drive bool=8'hFF and in_valid=1 -> result handle=0, count=1; second request not accepted until IDLE.
//  5. Accept, then assert reset=0 at scan idx=4
//     -> next cycle in_ready=1, out_valid=0, outputs=0; a fresh accept completes normally.
//  6. Back-to-back requests with out_ready=1 held -> accepts spaced exactly 10 edges apart; each result matches its own snapshot.

Source files
------------

// File: rtl/cell_result_collector.sv
// Snapshots per-cell response vectors after a broadcast and serially scans them for the
// lowest-handle asserting cell. Optional duplicate-match counter: define HIT_COUNT_EN.
module cell_result_collector #(
  parameter int NUM_CELLS = 8,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_CELLS-1:0]        cell_bool,
  input  logic [NUM_CELLS*DATA_W-1:0] cell_result,
  input  logic [NUM_CELLS*DATA_W-1:0] cell_context,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_hit,
  output logic [IDX_W-1:0]            out_handle,
  output logic [DATA_W-1:0]           out_value,
  output logic [DATA_W-1:0]           out_context,
  output logic [IDX_W:0]              out_hit_count
);

  localparam int SEL_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CELLS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                          state;
  logic [SEL_W-1:0]                idx;
  logic [NUM_CELLS-1:0]            snap_bool;
  logic [NUM_CELLS-1:0][DATA_W-1:0] snap_result;
  logic [NUM_CELLS-1:0][DATA_W-1:0] snap_context;

  logic accept, cur_hit;
  assign accept  = (state == IDLE) && in_valid;
  assign cur_hit = (state == SCAN) && snap_bool[idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_hit      <= 1'b0;
      out_handle   <= '0;
      out_value    <= '0;
      out_context  <= '0;
      idx          <= '0;
      snap_bool    <= '0;
      snap_result  <= '0;
      snap_context <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          snap_bool    <= cell_bool;
          snap_result  <= cell_result;
          snap_context <= cell_context;
          out_hit      <= 1'b0;
          out_handle   <= '0;
          out_value    <= '0;
          out_context  <= '0;
          idx          <= '0;
          in_ready     <= 1'b0;
          state        <= SCAN;
        end
        SCAN: begin
          // first hit is sticky so the lowest handle wins
          if (cur_hit && !out_hit) begin
            out_hit     <= 1'b1;
            out_handle  <= IDX_W'(idx);
            out_value   <= snap_result[idx];
            out_context <= snap_context[idx];
          end
          idx <= idx + SEL_W'(1);
          if (idx == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef HIT_COUNT_EN
  logic [IDX_W:0] hit_count;
  always_ff @(posedge clk) begin
    if (!reset)                       hit_count <= '0;
    else if (accept)                  hit_count <= '0;
    else if (cur_hit && hit_count != '1) hit_count <= hit_count + (IDX_W+1)'(1);
  end
  assign out_hit_count = hit_count;
`else
  assign out_hit_count = '0;
`endif

endmodule

// File: tb/tb_cell_result_collector.sv
// Randomized bench for cell_result_collector with a transaction-level reference model
// and hand-computed pins for the directed cases.
module tb_cell_result_collector;
  localparam int NC = 8, DW = 8, IW = 8, SCAN_LEN = 8;

  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [NC-1:0]    cell_bool = '0;
  logic [NC*DW-1:0] cell_result = '0, cell_context = '0;
  logic in_ready, out_valid, out_hit;
  logic [IW-1:0] out_handle;
  logic [DW-1:0] out_value, out_context;
  logic [IW:0]   out_hit_count;

  cell_result_collector #(.NUM_CELLS(NC), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cell_bool(cell_bool), .cell_result(cell_result), .cell_context(cell_context),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_handle(out_handle), .out_value(out_value), .out_context(out_context),
    .out_hit_count(out_hit_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  // reference model: busy flag plus edges elapsed since the accept
  bit m_busy = 0, m_zero = 1;
  int m_age = 0;
  logic m_hit;
  logic [IW-1:0] m_handle;
  logic [DW-1:0] m_val, m_ctx;
  logic [IW:0]   m_cnt;

  bit pin_en = 0, b2b = 0;
  logic pin_hit;
  logic [IW-1:0] pin_handle;
  logic [DW-1:0] pin_val, pin_ctx;
  logic [IW:0]   pin_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_done();
    return m_busy && m_age == SCAN_LEN;
  endfunction

  // compare then advance the model with the inputs the next edge will sample
  initial begin
    int last_acc = -1;
    forever begin
      @(negedge clk);
      cyc++;
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_done()));
      if (m_zero)
        chk("zero_outputs", 32'({out_hit, out_handle, out_value, out_context, out_hit_count} != '0), 32'(0));
      if (m_done()) begin
        chk("hit", 32'(out_hit), 32'(m_hit));
        chk("handle", 32'(out_handle), 32'(m_handle));
        chk("value", 32'(out_value), 32'(m_val));
        chk("context", 32'(out_context), 32'(m_ctx));
        chk("hit_count", 32'(out_hit_count), 32'(m_cnt));
        if (pin_en) begin
          chk("pin_hit", 32'(out_hit), 32'(pin_hit));
          chk("pin_handle", 32'(out_handle), 32'(pin_handle));
          chk("pin_value", 32'(out_value), 32'(pin_val));
          chk("pin_context", 32'(out_context), 32'(pin_ctx));
          chk("pin_count", 32'(out_hit_count), 32'(pin_cnt));
        end
      end
      if (!b2b) last_acc = -1;
      else if (in_ready && in_valid && reset) begin
        if (last_acc >= 0) chk("accept_spacing", 32'(cyc - last_acc), 32'(SCAN_LEN + 2));
        last_acc = cyc;
      end
      if (!reset) begin
        m_busy = 0; m_zero = 1;
      end else if (!m_busy) begin
        if (in_valid) begin
          m_hit = 0; m_handle = '0; m_val = '0; m_ctx = '0; m_cnt = '0;
          for (int i = 0; i < NC; i++)
            if (cell_bool[i]) begin
              if (!m_hit) begin
                m_hit = 1; m_handle = IW'(i);
                m_val = cell_result[i*DW +: DW]; m_ctx = cell_context[i*DW +: DW];
              end
              m_cnt = m_cnt + 1'b1;
            end
`ifndef HIT_COUNT_EN
          m_cnt = '0;
`endif
          m_busy = 1; m_age = 0; m_zero = 0;
        end
      end else if (m_age == SCAN_LEN) begin
        if (out_ready) m_busy = 0;
      end else m_age++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!m_done() && n < 100) begin step(); n++; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 100) begin step(); n++; end
  endtask

  task automatic randomize_vectors(input bit sparse);
    cell_bool = sparse ? NC'($urandom & $urandom & $urandom) : NC'($urandom);
    for (int i = 0; i < NC; i++) begin
      cell_result[i*DW +: DW]  = DW'($urandom);
      cell_context[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic send();
    in_valid = 1; step(); in_valid = 0;
  endtask

  task automatic finish_txn(input int stall);
    out_ready = 0; wait_done();
    repeat (stall) step();
    out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic set_pin(input logic h, input logic [IW-1:0] hd, input logic [DW-1:0] v,
                         input logic [DW-1:0] c, input logic [IW:0] n);
    pin_hit = h; pin_handle = hd; pin_val = v; pin_ctx = c;
`ifdef HIT_COUNT_EN
    pin_cnt = n;
`else
    pin_cnt = '0;
`endif
    pin_en = 1;
  endtask

  initial begin
    repeat (3) step();
    reset = 1; step();

    // directed: two hits, lowest wins
    randomize_vectors(0);
    cell_bool = 8'b0010_0100;
    cell_result[2*DW +: DW] = 8'h11; cell_context[2*DW +: DW] = 8'h03;
    cell_result[5*DW +: DW] = 8'h22;
    set_pin(1, 2, 8'h11, 8'h03, 2);
    send(); finish_txn(0); pin_en = 0; step();

    // no hit
    randomize_vectors(0); cell_bool = 8'h00;
    set_pin(0, 0, 0, 0, 0);
    send(); finish_txn(0); pin_en = 0;

    // hit on the last cell with host back-pressure
    randomize_vectors(0); cell_bool = 8'h80; cell_result[7*DW +: DW] = 8'hAB;
    set_pin(1, 7, 8'hAB, cell_context[7*DW +: DW], 1);
    send(); finish_txn(5); pin_en = 0;

    // inputs changing during SCAN are ignored
    randomize_vectors(0); cell_bool = 8'h01;
    set_pin(1, 0, cell_result[7:0], cell_context[7:0], 1);
    send();
    cell_bool = 8'hFF; in_valid = 1;
    for (int i = 0; i < NC; i++) cell_result[i*DW +: DW] = 8'hEE;
    finish_txn(0); pin_en = 0;
    in_valid = 0; wait_idle(); wait_done(); finish_txn(0);

    // reset mid-scan, then a fresh transaction
    randomize_vectors(0); send();
    repeat (4) step();
    reset = 0; step(); reset = 1; step();
    randomize_vectors(1); send(); finish_txn(1);

    // back-to-back with out_ready held
    b2b = 1; out_ready = 1; in_valid = 1;
    for (int k = 0; k < 45; k++) begin randomize_vectors(k[0]); step(); end
    in_valid = 0; wait_idle(); b2b = 0; out_ready = 0;

    // random traffic with stalls, scan-time noise and occasional resets
    for (int t = 0; t < 40; t++) begin
      randomize_vectors($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 5) == 0) cell_bool = '0;
      send();
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, SCAN_LEN)) step();
        reset = 0; step(); reset = 1; step();
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          randomize_vectors(0); in_valid = 1; step(); in_valid = 0;
        end
        finish_txn($urandom_range(0, 3));
      end
      repeat ($urandom_range(0, 2)) step();
    end

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
